wb_trace_buffer: RTL

- Sits directly downstream of the pipelined CPU core and consumes its writeback-stage debug commit stream (have_inst, pc, ena, reg, value).
- Buffers each retired instruction as a trace record in a FIFO.
- Streams records out over a valid/ready handshake to a trace comparator or UART dumper.
- Keeps commit and drop statistics so back-pressure never stalls the core.

---
 rtl/trace_pkg.sv | 46 ++++
 rtl/trace_fifo.sv | 64 ++++++
 rtl/wb_trace_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared field widths and record layouts for the writeback trace buffer.
//   PC_W / REG_W / DATA_W / STAMP_W : widths of the trace record fields
//   CORE_W : record width without the cycle stamp
//   REC_W  : full record width including the cycle stamp
//   trace_core_t : {pc, ena, rd, value}        (stored when no stamp)
//   trace_rec_t  : {pc, ena, rd, value, cycle} (stored with the stamp)
// The destination-register field is named rd because "reg" is a keyword.
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam int PC_W    = 32;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int STAMP_W = 32;

  localparam int CORE_W  = PC_W + 1 + REG_W + DATA_W;
  localparam int REC_W   = CORE_W + STAMP_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              ena;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } trace_core_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic               ena;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  value;
    logic [STAMP_W-1:0] cycle;
  } trace_rec_t;

  // Strip the cycle stamp from a full record.
  function automatic trace_core_t rec_core(input trace_rec_t r);
    trace_core_t c;
    c.pc    = r.pc;
    c.ena   = r.ena;
    c.rd    = r.rd;
    c.value = r.value;
    return c;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Generic DEPTH x W first-word-fall-through synchronous FIFO.
// The caller decides acceptance: push must only be asserted when there is
// room (or a pop happens in the same cycle), pop only when level != 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of pointers and level (priority)
//   push, din  : write request and data
//   pop        : advance the head
//   dout       : head entry (combinational read of the storage)
//   level      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries data only; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !clr) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
// Captures the CPU writeback-stage commit stream into a FWFT FIFO of trace
// records and streams them out over valid/ready. The core is never stalled:
// a record arriving with no room is dropped and counted instead.
// Build option: define TRACE_CYCLE_STAMP_EN to add a free-running 32-bit
// cycle counter whose value is stored with each record and shown on
// out_cycle; without it no stamp is stored and out_cycle is 0.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : synchronous clear (FIFO, counters, overflow, stamp)
//   wb_have_inst    : a real instruction retires this cycle
//   wb_pc/ena/reg/value : retiring instruction's trace fields
//   out_valid/out_ready : output handshake, head record on out_*
//   out_pc/ena/reg/value/cycle : head record, zero when out_valid = 0
//   level           : FIFO occupancy
//   overflow        : sticky, set once any record was dropped
//   commit_cnt      : retirements seen (accepted or dropped)
//   drop_cnt        : retirements dropped because the FIFO was full
// ---------------------------------------------------------------------------
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wb_have_inst,
  input  logic [31:0]            wb_pc,
  input  logic                   wb_ena,
  input  logic [4:0]             wb_reg,
  input  logic [31:0]            wb_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic                   out_ena,
  output logic [4:0]             out_reg,
  output logic [31:0]            out_value,
  output logic [31:0]            out_cycle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       commit_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int FIFO_W = REC_W;
`else
  localparam int FIFO_W = CORE_W;
`endif

  logic              w_valid;
  logic              w_pop;
  logic              w_push_req;
  logic              w_room;
  logic              w_accept;
  logic              w_reject;
  logic [LVL_W-1:0]  w_level;
  logic [FIFO_W-1:0] w_din;
  logic [FIFO_W-1:0] w_dout;
  trace_core_t       w_in_core;
  trace_core_t       w_head_core;

  logic              r_overflow;
  logic [CNT_W-1:0]  r_commit_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  assign w_valid    = (w_level != '0);
  assign w_pop      = w_valid & out_ready;
  // clr swallows the retirement presented in the same cycle.
  assign w_push_req = wb_have_inst & ~clr;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_room     = (w_level < LVL_W'(DEPTH)) | w_pop;
  assign w_accept   = w_push_req & w_room;
  assign w_reject   = w_push_req & ~w_room;

  always_comb begin
    w_in_core       = '0;
    w_in_core.pc    = wb_pc;
    w_in_core.ena   = wb_ena;
    w_in_core.rd    = wb_reg;
    w_in_core.value = wb_value;
  end

`ifdef TRACE_CYCLE_STAMP_EN
  logic [STAMP_W-1:0] r_cycle;
  trace_rec_t         w_in_rec;
  trace_rec_t         w_head_rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_cycle <= '0;
    else if (clr) r_cycle <= '0;
    else          r_cycle <= r_cycle + STAMP_W'(1);
  end

  always_comb begin
    w_in_rec       = '0;
    w_in_rec.pc    = w_in_core.pc;
    w_in_rec.ena   = w_in_core.ena;
    w_in_rec.rd    = w_in_core.rd;
    w_in_rec.value = w_in_core.value;
    w_in_rec.cycle = r_cycle;
  end

  assign w_din       = w_in_rec;
  assign w_head_rec  = w_dout;
  assign w_head_core = rec_core(w_head_rec);
  assign out_cycle   = w_valid ? w_head_rec.cycle : '0;
`else
  assign w_din       = w_in_core;
  assign w_head_core = w_dout;
  assign out_cycle   = '0;
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .level (w_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_commit_cnt <= '0;
      r_drop_cnt   <= '0;
    end else if (clr) begin
      r_overflow   <= 1'b0;
      r_commit_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_push_req) r_commit_cnt <= r_commit_cnt + CNT_W'(1);
      if (w_reject) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        r_overflow <= 1'b1;
      end
    end
  end

  // Output fields are forced to zero whenever no record is presented.
  assign out_valid  = w_valid;
  assign out_pc     = w_valid ? w_head_core.pc    : '0;
  assign out_ena    = w_valid ? w_head_core.ena   : 1'b0;
  assign out_reg    = w_valid ? w_head_core.rd    : '0;
  assign out_value  = w_valid ? w_head_core.value : '0;
  assign level      = w_level;
  assign overflow   = r_overflow;
  assign commit_cnt = r_commit_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule
